// File: rtl/mac_pe_acc.sv
// Multi-term multiply-accumulate PE with systolic a/b/c forwarding
// and a saturated result qualified by a one-cycle done pulse.
module mac_pe_acc #(
  parameter int A_W   = 4,
  parameter int B_W   = 4,
  parameter int C_W   = 8,
  parameter int K_LEN = 1,
  parameter int RES_W = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             valid_in,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic [C_W-1:0]   c,
  output logic [A_W-1:0]   a_out,
  output logic [B_W-1:0]   b_out,
  output logic [C_W-1:0]   c_out,
  output logic             valid_out,
  output logic [RES_W-1:0] result,
  output logic             sat,
  output logic             busy,
  output logic             done
);

  localparam int P_W   = A_W + B_W + $clog2(K_LEN);
  localparam int ACC_W = ((C_W > P_W) ? C_W : P_W) + 1;
  localparam int CNT_W = $clog2(K_LEN + 1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W-1:0] prod;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             take;
  logic             beat;
  logic             fin;
  logic [RES_W-1:0] res_nxt;
  logic             sat_nxt;

  always_comb begin
    take    = (state == IDLE) && start;
    beat    = valid_in && (take || (state == ACC));
    prod    = ACC_W'(a) * ACC_W'(b);
    acc_nxt = (take ? ACC_W'(c) : acc)
            + (beat ? prod : '0);
    cnt_nxt = (take ? '0 : cnt) + CNT_W'(beat);
    fin     = beat && (cnt_nxt == CNT_W'(K_LEN));
  end

  // Clamp only exists when the result is narrower than the accumulator.
  generate
    if (RES_W >= ACC_W) begin : g_wide
      always_comb begin
        res_nxt = RES_W'(acc_nxt);
        sat_nxt = 1'b0;
      end
    end else begin : g_clamp
      always_comb begin
        sat_nxt = |acc_nxt[ACC_W-1:RES_W];
        res_nxt = sat_nxt ? '1 : acc_nxt[RES_W-1:0];
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      a_out     <= '0;
      b_out     <= '0;
      c_out     <= '0;
      valid_out <= 1'b0;
      result    <= '0;
      sat       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      a_out     <= a;
      b_out     <= b;
      valid_out <= valid_in;
      done      <= 1'b0;
      if (take || (state == ACC)) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
      end
      if (take) c_out <= c;
      if (fin) begin
        result <= res_nxt;
        sat    <= sat_nxt;
        done   <= 1'b1;
        state  <= IDLE;
        busy   <= 1'b0;
      end else if (take) begin
        state <= ACC;
        busy  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_pe_acc.sv
// Bench for mac_pe_acc: three parameter sets share one stimulus stream
// and are checked every cycle against an operation-level model.
module tb_mac_pe_acc;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       valid_in;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] c;

  logic [3:0]  ao0, ao1, ao2;
  logic [3:0]  bo0, bo1, bo2;
  logic [7:0]  co0, co1, co2;
  logic        vo0, vo1, vo2;
  logic [8:0]  r0;
  logic [10:0] r1;
  logic [5:0]  r2;
  logic        s0, s1, s2;
  logic        bz0, bz1, bz2;
  logic        d0, d1, d2;

  int checks = 0;
  int failures = 0;

  localparam int KS[3]  = '{1, 4, 4};
  localparam int RWS[3] = '{9, 11, 6};

  bit act[3];
  int sum[3];
  int n[3];
  int mres[3];
  bit msat[3];
  bit mdone[3];
  int mcout[3];
  int ma, mb, mv;

  always #5 clock = ~clock;

  mac_pe_acc dut0 (
    .clock(clock), .reset(reset), .start(start),
    .valid_in(valid_in), .a(a), .b(b), .c(c),
    .a_out(ao0), .b_out(bo0), .c_out(co0),
    .valid_out(vo0), .result(r0), .sat(s0),
    .busy(bz0), .done(d0)
  );

  mac_pe_acc #(.K_LEN(4), .RES_W(11)) dut1 (
    .clock(clock), .reset(reset), .start(start),
    .valid_in(valid_in), .a(a), .b(b), .c(c),
    .a_out(ao1), .b_out(bo1), .c_out(co1),
    .valid_out(vo1), .result(r1), .sat(s1),
    .busy(bz1), .done(d1)
  );

  mac_pe_acc #(.K_LEN(4), .RES_W(6)) dut2 (
    .clock(clock), .reset(reset), .start(start),
    .valid_in(valid_in), .a(a), .b(b), .c(c),
    .a_out(ao2), .b_out(bo2), .c_out(co2),
    .valid_out(vo2), .result(r2), .sat(s2),
    .busy(bz2), .done(d2)
  );

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 3; i++) begin
      act[i] = 0; sum[i] = 0; n[i] = 0;
      mres[i] = 0; msat[i] = 0; mdone[i] = 0;
      mcout[i] = 0;
    end
    ma = 0; mb = 0; mv = 0;
  endtask

  task automatic madv();
    int lim;
    for (int i = 0; i < 3; i++) begin
      mdone[i] = 0;
      if (!act[i] && start) begin
        act[i] = 1; sum[i] = int'(c);
        n[i] = 0; mcout[i] = int'(c);
      end
      if (act[i] && valid_in) begin
        sum[i] += int'(a) * int'(b);
        n[i]++;
      end
      if (act[i] && n[i] == KS[i]) begin
        lim = (1 << RWS[i]) - 1;
        msat[i] = sum[i] > lim;
        mres[i] = msat[i] ? lim : sum[i];
        mdone[i] = 1;
        act[i] = 0;
      end
    end
    ma = int'(a); mb = int'(b); mv = int'(valid_in);
  endtask

  task automatic compare();
    int ga[3], gb[3], gc[3], gv[3];
    int gr[3], gs[3], gbz[3], gd[3];
    ga = '{int'(ao0), int'(ao1), int'(ao2)};
    gb = '{int'(bo0), int'(bo1), int'(bo2)};
    gc = '{int'(co0), int'(co1), int'(co2)};
    gv = '{int'(vo0), int'(vo1), int'(vo2)};
    gr = '{int'(r0), int'(r1), int'(r2)};
    gs = '{int'(s0), int'(s1), int'(s2)};
    gbz = '{int'(bz0), int'(bz1), int'(bz2)};
    gd = '{int'(d0), int'(d1), int'(d2)};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d_a_out", i), ga[i], ma);
      chk($sformatf("d%0d_b_out", i), gb[i], mb);
      chk($sformatf("d%0d_c_out", i), gc[i], mcout[i]);
      chk($sformatf("d%0d_valid_out", i), gv[i], mv);
      chk($sformatf("d%0d_result", i), gr[i], mres[i]);
      chk($sformatf("d%0d_sat", i), gs[i], int'(msat[i]));
      chk($sformatf("d%0d_busy", i), gbz[i], int'(act[i]));
      chk($sformatf("d%0d_done", i), gd[i], int'(mdone[i]));
    end
  endtask

  task automatic step();
    @(posedge clock);
    if (!reset) mreset();
    else madv();
    #1;
    compare();
  endtask

  task automatic drive(bit st, bit v, int aa, int bb, int cc);
    start = st; valid_in = v;
    a = 4'(aa); b = 4'(bb); c = 8'(cc);
    step();
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    mreset();
    compare();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; valid_in = 1'b0;
    a = '0; b = '0; c = '0;
    mreset();
    #2;
    compare();
    step();
    step();
    reset = 1'b1;

    drive(1, 1, 15, 15, 255);
    chk("dflt_res", int'(r0), 480);
    chk("dflt_cout", int'(co0), 255);
    chk("dflt_done", int'(d0), 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    drive(1, 1, 2, 3, 10);
    drive(0, 1, 4, 5, 0);
    drive(0, 0, 9, 9, 0);
    drive(1, 1, 1, 1, 99);
    drive(0, 1, 7, 2, 0);
    chk("k4_res", int'(r1), 10 + 2*3 + 4*5 + 1*1 + 7*2);
    chk("k4_cout", int'(co1), 10);
    chk("k4_done", int'(d1), 1);
    drive(0, 0, 0, 0, 0);
    chk("k4_pulse", int'(d1), 0);

    drive(1, 1, 15, 15, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 15, 15, 0);
    chk("sat_res", int'(r2), 63);
    chk("sat_flag", int'(s2), 1);
    drive(1, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 1, 0);
    chk("unsat_res", int'(r2), 4);
    chk("unsat_flag", int'(s2), 0);

    drive(1, 1, 3, 3, 5);
    drive(0, 1, 2, 2, 0);
    async_reset();
    chk("rst_res", int'(r1), 0);
    drive(1, 1, 1, 2, 7);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 2, 0);
    chk("fresh_res", int'(r1), 15);

    for (int i = 0; i < 40; i++)
      drive(0, 1'($urandom), $urandom, $urandom, $urandom);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            $urandom, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
